// File: rtl/lsu_ctrl_if.sv
// Core-side request and data-memory bus signals of the load/store sequencer.
interface lsu_ctrl_if #(
  parameter int XLEN = 32
);
  // Core side: a request transfers on a rising clk edge where req=1 and ready=1;
  // req with ready=0 is dropped, not queued. Bus side: mem_valid and every
  // mem_* output stay constant from assertion until the edge where mem_ack=1.
  logic            req;
  logic            we;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            done;
  logic            err;
  logic [XLEN-1:0] rdata;
  logic            mem_valid;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_ack, mem_rdata,
    output ready, done, err, rdata, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_ack, mem_rdata,
    input  ready, done, err, rdata, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time to a word-aligned valid/ack bus.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into err pulses.
module lsu_extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_uext,
  output logic [OUT_W-1:0] o_data
);
  assign o_data = {{(OUT_W-IN_W){~i_uext & i_data[IN_W-1]}}, i_data};
endmodule

module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          r_state, w_next_state;
  logic            r_we, w_we_nxt;
  logic [2:0]      r_funct3, w_funct3_nxt;
  logic [1:0]      r_off, w_off_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [XLEN-1:0] r_rdata, w_rdata_nxt;
  logic            r_mem_valid, w_mem_valid_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0]      r_mem_be, w_mem_be_nxt;
  logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;

  logic            w_legal;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_lane_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_byte_ext, w_half_ext, w_load_val;

  always_comb begin
    w_legal = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~bus.we;
      default:                w_legal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
  // Without the trap, halfword/word accesses silently use the truncated address.
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be         = 4'b1111;
    w_lane_wdata = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << bus.addr[1:0];
        w_lane_wdata = {(XLEN/8){bus.wdata[7:0]}};
      end
      2'b01: begin
        w_be         = 4'b0011 << {bus.addr[1], 1'b0};
        w_lane_wdata = {(XLEN/16){bus.wdata[15:0]}};
      end
      default: begin
        w_be         = 4'b1111;
        w_lane_wdata = bus.wdata;
      end
    endcase
  end

  // Load lane selection uses the offset latched at request time.
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_off)
      2'd0: w_byte = bus.mem_rdata[7:0];
      2'd1: w_byte = bus.mem_rdata[15:8];
      2'd2: w_byte = bus.mem_rdata[23:16];
      2'd3: w_byte = bus.mem_rdata[31:24];
      default: w_byte = bus.mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  lsu_extend #(.IN_W(8),  .OUT_W(XLEN)) u_ext8  (.i_data(w_byte), .i_uext(r_funct3[2]), .o_data(w_byte_ext));
  lsu_extend #(.IN_W(16), .OUT_W(XLEN)) u_ext16 (.i_data(w_half), .i_uext(r_funct3[2]), .o_data(w_half_ext));

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_load_val = w_byte_ext;
      2'b01:   w_load_val = w_half_ext;
      default: w_load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_next_state    = r_state;
    w_we_nxt        = r_we;
    w_funct3_nxt    = r_funct3;
    w_off_nxt       = r_off;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_be_nxt    = r_mem_be;
    w_mem_wdata_nxt = r_mem_wdata;
    w_tcnt_nxt      = r_tcnt;
    case (r_state)
      IDLE: begin
        w_tcnt_nxt = '0;
        if (bus.req) begin
          w_we_nxt     = bus.we;
          w_funct3_nxt = bus.funct3;
          w_off_nxt    = bus.addr[1:0];
          if (!w_legal || w_misalign) begin
            w_err_nxt    = 1'b1;
            w_next_state = RESP;
          end else begin
            w_mem_valid_nxt = 1'b1;
            w_mem_we_nxt    = bus.we;
            w_mem_addr_nxt  = {bus.addr[XLEN-1:2], 2'b00};
            w_mem_be_nxt    = bus.we ? w_be : 4'b1111;
            w_mem_wdata_nxt = bus.we ? w_lane_wdata : '0;
            w_next_state    = ACCESS;
          end
        end
      end
      ACCESS: begin
        w_tcnt_nxt = r_tcnt + 1'b1;
        // Ack is checked first so an ack on the final allowed cycle still completes.
        if (bus.mem_ack) begin
          w_mem_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          if (!r_we) w_rdata_nxt = w_load_val;
          w_next_state    = RESP;
        end else if ((TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1))) begin
          w_mem_valid_nxt = 1'b0;
          w_err_nxt       = 1'b1;
          w_next_state    = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
      r_tcnt      <= '0;
    end else begin
      r_state     <= w_next_state;
      r_we        <= w_we_nxt;
      r_funct3    <= w_funct3_nxt;
      r_off       <= w_off_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_tcnt      <= w_tcnt_nxt;
    end
  end

  assign bus.ready     = (r_state == IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes expected bus and core responses,
// a memory responder and a response monitor pop and compare them.
module tb_lsu_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  lsu_ctrl_if #(.XLEN(32)) bus ();

  lsu_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] exp_bus_q[$];   // {mem_we, mem_addr, mem_be, mem_wdata}
  logic [33:0] exp_q[$];       // {done, err, rdata}

  int          g_ack_at    = 0;   // mem_valid cycle (1-based) carrying the ack; 0 = never
  logic [31:0] g_mrd       = '0;
  logic        g_stray     = 1'b0;
  int          g_valid_len = 0;
  int          r_cnt       = 0;
  logic [68:0] r_snap      = '0;
  logic        r_unstable  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Memory responder
  always @(negedge clk) begin
    logic [68:0] e;
    logic [68:0] cur;
    cur = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
    if (bus.mem_valid) begin
      r_cnt++;
      if (r_cnt == 1) begin
        r_snap     = cur;
        r_unstable = 1'b0;
        if (exp_bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bus act=%0h exp=none", cur);
        end else begin
          e = exp_bus_q.pop_front();
          chk("bus_txn", cur, e);
        end
      end else if (cur !== r_snap) begin
        r_unstable = 1'b1;
      end
      bus.mem_ack   = (r_cnt == g_ack_at);
      bus.mem_rdata = (r_cnt == g_ack_at) ? g_mrd : 32'h5555_AAAA;
    end else begin
      if (r_cnt != 0) begin
        g_valid_len = r_cnt;
        chk("bus_hold", r_unstable, 1'b0);
      end
      r_cnt         = 0;
      bus.mem_ack   = g_stray;
      bus.mem_rdata = 32'h5555_AAAA;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus.done || bus.err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp act=%0h exp=none", {bus.done, bus.err, bus.rdata});
      end else begin
        e = exp_q.pop_front();
        chk("resp", {bus.done, bus.err, bus.rdata}, e);
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_wait act=0 exp=1");
    end
  endtask

  // Issue one request from a negedge; expected latency follows the documented timeline.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] mrd,
                        input logic bus_exp, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic e_err, input logic [31:0] e_rd,
                        input logic hold);
    int lat;
    int e_lat;
    int e_vlen;
    wait_ready();
    g_ack_at    = ack_at;
    g_mrd       = mrd;
    g_valid_len = -1;
    if (bus_exp) exp_bus_q.push_back({w, e_addr, e_be, e_wd});
    exp_q.push_back({~e_err, e_err, e_rd});
    bus.req    = 1'b1;
    bus.we     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    @(negedge clk);
    lat = 1;
    if (!hold) bus.req = 1'b0;
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.req = 1'b0;
    e_vlen = (ack_at == 0) ? 16 : ack_at;
    e_lat  = !bus_exp ? 2 : (e_vlen + 2);
    chk("latency", lat, e_lat);
    if (bus_exp) chk("valid_len", g_valid_len, e_vlen);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = '0;
    bus.wdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done_err", {bus.done, bus.err}, 2'b00);
    chk("rst_mem_ctl", {bus.mem_valid, bus.mem_we, bus.mem_be}, 6'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Loads: byte/halfword/word lanes, signed and unsigned
    do_req(0, 3'b000, 32'h103, 0, 3, 32'h8F00_0000, 1, 32'h100, 4'hF, 0, 0, 32'hFFFF_FF8F, 0);
    do_req(0, 3'b100, 32'h103, 0, 3, 32'h8F00_0000, 1, 32'h100, 4'hF, 0, 0, 32'h0000_008F, 0);
    do_req(0, 3'b001, 32'h22,  0, 1, 32'h800F_1234, 1, 32'h20,  4'hF, 0, 0, 32'hFFFF_800F, 0);
    do_req(0, 3'b101, 32'h22,  0, 2, 32'h800F_1234, 1, 32'h20,  4'hF, 0, 0, 32'h0000_800F, 1);
    do_req(0, 3'b010, 32'h20,  0, 4, 32'h800F_1234, 1, 32'h20,  4'hF, 0, 0, 32'h800F_1234, 0);

    // Stores: lane replication and byte enables, rdata untouched
    do_req(1, 3'b000, 32'h41, 32'hAABB_CC5A, 2, 0, 1, 32'h40, 4'b0010, 32'h5A5A_5A5A, 0, 32'h800F_1234, 0);
    do_req(1, 3'b001, 32'h42, 32'h1234_BEEF, 1, 0, 1, 32'h40, 4'b1100, 32'hBEEF_BEEF, 0, 32'h800F_1234, 0);
    do_req(1, 3'b010, 32'h44, 32'hDEAD_BEEF, 2, 0, 1, 32'h44, 4'b1111, 32'hDEAD_BEEF, 0, 32'h800F_1234, 0);
    do_req(1, 3'b000, 32'h43, 32'h0000_0077, 1, 0, 1, 32'h40, 4'b1000, 32'h7777_7777, 0, 32'h800F_1234, 0);
    do_req(1, 3'b001, 32'h40, 32'hCAFE_0102, 1, 0, 1, 32'h40, 4'b0011, 32'h0102_0102, 0, 32'h800F_1234, 0);

    do_req(0, 3'b000, 32'h0, 0, 1, 32'h1122_337F, 1, 32'h0, 4'hF, 0, 0, 32'h0000_007F, 0);
    do_req(0, 3'b001, 32'h0, 0, 1, 32'h0000_8001, 1, 32'h0, 4'hF, 0, 0, 32'hFFFF_8001, 0);
    do_req(0, 3'b100, 32'h1, 0, 1, 32'h0000_A500, 1, 32'h0, 4'hF, 0, 0, 32'h0000_00A5, 0);
    do_req(0, 3'b000, 32'h2, 0, 1, 32'h00C3_0000, 1, 32'h0, 4'hF, 0, 0, 32'hFFFF_FFC3, 0);

    // Stray ack while idle must be ignored
    g_stray = 1'b1;
    repeat (2) @(negedge clk);
    g_stray = 1'b0;
    repeat (2) @(negedge clk);
    do_req(0, 3'b010, 32'h24, 0, 1, 32'h0BAD_F00D, 1, 32'h24, 4'hF, 0, 0, 32'h0BAD_F00D, 0);

    // Timeout, then ack on the last allowed cycle
    do_req(0, 3'b010, 32'h80, 0, 0,  32'hFFFF_FFFF, 1, 32'h80, 4'hF, 0, 1, 32'h0BAD_F00D, 0);
    do_req(0, 3'b010, 32'h84, 0, 16, 32'h1357_9BDF, 1, 32'h84, 4'hF, 0, 0, 32'h1357_9BDF, 0);

    // Illegal funct3 combinations
    do_req(0, 3'b011, 32'h8, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);
    do_req(1, 3'b100, 32'h8, 32'h55, 1, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);
    do_req(0, 3'b111, 32'h8, 0, 1, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);
    do_req(1, 3'b101, 32'h8, 32'h55, 1, 0, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);

    // Misaligned halfword/word
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 3'b010, 32'h02, 0, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);
    do_req(0, 3'b001, 32'h23, 0, 1, 32'hABCD_0000, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0);
`else
    do_req(0, 3'b010, 32'h02, 0, 1, 32'hCAFE_F00D, 1, 32'h00, 4'hF, 0, 0, 32'hCAFE_F00D, 0);
    do_req(0, 3'b001, 32'h23, 0, 1, 32'hABCD_0000, 1, 32'h20, 4'hF, 0, 0, 32'hFFFF_ABCD, 0);
`endif

    // Reset in the middle of a bus access
    wait_ready();
    g_ack_at   = 0;
    exp_bus_q.push_back({1'b0, 32'h30, 4'hF, 32'h0});
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h30;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", bus.mem_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", bus.mem_valid, 1'b0);
    chk("rst_mid_ready", bus.ready, 1'b1);
    chk("rst_mid_done_err", {bus.done, bus.err}, 2'b00);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(0, 3'b010, 32'h10, 0, 2, 32'h0102_0304, 1, 32'h10, 4'hF, 0, 0, 32'h0102_0304, 0);

    repeat (5) @(negedge clk);
    chk("resp_q_empty", exp_q.size(), 0);
    chk("bus_q_empty", exp_bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the data-memory bus.
- Accepts one request at a time and generates a word-aligned bus transaction with byte enables, waiting for a valid/ack handshake.
- Loads: selects the addressed byte or halfword lane, then sign- or zero-extends it to 32 bits using the existing extend component (8->32 and 16->32 instances).
- Reports completion or error to the core with single-cycle pulses.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 16, maximum ACCESS cycles without mem_ack before err; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  core request; sampled only when ready=1.
- we  in  1  1=store, 0=load.
- funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only).
- addr  in  XLEN  byte address.
- wdata  in  XLEN  store data, right-aligned.
- ready  out  1  controller idle; request accepted this cycle if req=1.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on illegal funct3, timeout, or misalignment (see Optional Feature).
- rdata  out  XLEN  extended load result; valid from done and held until the next successful load.
- mem_valid  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}.
- mem_be  out  4  byte enables; meaningful for stores, 4'b1111 for loads.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_ack  in  1  bus completion; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  bus read data.

Behaviour:
- Reset values: state IDLE; ready=1; done=0; err=0; mem_valid=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0; rdata=0; timeout counter=0.
- All outputs except ready are registered; ready is decoded from the state.
- States: IDLE, ACCESS, RESP.
- IDLE, req=1: latch we/funct3/addr/wdata.
  - Legal request: next state ACCESS, mem_valid=1 in the following cycle.
  - Illegal request: next state RESP with err pending and no bus cycle. Illegal means funct3 011/110/111, or a store with funct3[2]=1.
- ACCESS: mem_valid and all mem_* outputs held stable until mem_ack.
  - On mem_ack: mem_valid=0 next cycle; for loads, rdata is captured; next state RESP with done pending.
  - Timeout counter increments each ACCESS cycle. When TIMEOUT!=0 and the count reaches TIMEOUT without ack: mem_valid=0, next state RESP with err pending, rdata unchanged.
- RESP: done or err high for exactly this cycle; next state IDLE.
- Latency: req accepted at cycle 0, mem_valid high from cycle 1, ack at cycle k>=1, done at k+1, ready at k+2. Minimum 3 cycles request-to-ready.
- Store lanes, with o=addr[1:0]:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<o.
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<{o[1],1'b0}.
  - SW: mem_wdata=wdata, mem_be=4'b1111.
- Load lanes:
  - B/BU use byte mem_rdata[8*o+:8].
  - H/HU use halfword mem_rdata[16*o[1]+:16].
  - W uses the full word.
  - Extend control: uext=funct3[2].
- Stores leave rdata unchanged.
- req while not ready is ignored (no queue).
- mem_ack outside ACCESS is ignored.
- If an ack arrives in the same cycle the timeout is reached, the ack wins (done, not err).
- Reset asserted mid-transaction: mem_valid drops asynchronously, state goes to IDLE, and no done or err is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a legal request with H/HU/SH at addr[0]=1, or W/SW at addr[1:0]!=0, goes directly to RESP with err=1. No bus transaction occurs and rdata is unchanged.
- Undefined: no misalignment check. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. The access proceeds normally on the truncated address.

Test Plan:
- LB at addr 0x103 with mem_rdata=0x8F00_0000 and ack 2 cycles after mem_valid -> mem_addr=0x100, mem_be=4'b1111, rdata=0xFFFF_FF8F, done 1 cycle after ack; LBU with the same stimulus -> rdata=0x0000_008F.
- LH/LHU at 0x22 with mem_rdata=0x800F_1234 -> rdata=0xFFFF_800F / 0x0000_800F; LW at 0x20 -> rdata=0x800F_1234.
- SB at 0x41 with wdata=0xAABB_CC5A -> mem_we=1, mem_be=4'b0010, mem_wdata=0x5A5A_5A5A; SH at 0x42 with wdata=0x1234_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_BEEF; rdata unchanged after both.
- No ack with TIMEOUT=16 -> mem_valid high 16 cycles then low, one err pulse, done never asserted; an ack exactly in cycle 16 -> done, no err.
- funct3=011 load and funct3=100 store -> err pulse 1 cycle after req, mem_valid never asserted; with LSU_MISALIGN_TRAP_EN defined, LW at 0x02 -> err, no bus cycle; undefined -> mem_addr=0x00, done.
- Reset asserted while mem_valid=1 -> mem_valid=0 immediately, ready=1, no done or err; a new LW then completes normally.
